// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: definitions shared by the UART receiver and transmitter.
//   UART_ETU_CYCLES : default bit period in clk cycles. The receiver and the
//                     transmitter both use this value, so they always agree.
//   uart_rx_state_t : receiver state encoding (3 bits).
//   maj3()          : 2-of-3 majority vote. Used when the receiver is built
//                     with UART_RX_MAJORITY_EN.
package uart_rx_pkg;

    localparam int UART_ETU_CYCLES = 434;

    typedef enum logic [2:0] {
        UART_RX_IDLE  = 3'd0,
        UART_RX_START = 3'd1,
        UART_RX_DATA  = 3'd2,
        UART_RX_STOP  = 3'd3,
        UART_RX_BREAK = 3'd4
    } uart_rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: synchronizer chain for asynchronous inputs. Every flop resets
// to 1, which is the idle level of a UART line.
// Ports:
//   clk : system clock
//   rst : asynchronous reset, active low
//   d   : asynchronous input (WIDTH bits)
//   q   : synchronized output, delayed by STAGES clk cycles
// Parameters:
//   WIDTH  : number of independent bits that are synchronized
//   STAGES : flop count. The default of 2 is the normal synchronizer.
//            STAGES=1 lets a caller reach the intermediate stage.
module uart_rx_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [STAGES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) pipe[i] <= '1;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. It samples each bit at mid-bit using an ETU
// counter. A good frame produces a one-cycle valid pulse and updates
// data_in. A frame whose stop bit is low produces a one-cycle frame_err
// pulse and leaves data_in unchanged.
// Ports:
//   clk       : system clock
//   rst       : asynchronous reset, active low
//   rxd       : serial line, asynchronous to clk, idle high
//   data_in   : last good byte received (LSB is first on the line)
//   valid     : one-cycle pulse when data_in updates
//   frame_err : one-cycle pulse when the stop bit samples 0
//   busy      : high from start-edge detection until the return to IDLE
// Build option:
//   UART_RX_MAJORITY_EN : each start, data and stop decision is a 2-of-3 vote
//   of rx_s at the nominal sample clock and the clocks just before and just
//   after it. The vote still resolves on the nominal clock.
//
// state         | meaning
// --------------+--------------------------------------------------------
// UART_RX_IDLE  | line idle, waiting for a low level on rx_s
// UART_RX_START | counting to mid-start-bit; a high sample there is a glitch
// UART_RX_DATA  | sampling 8 data bits, one per ETU, LSB first
// UART_RX_STOP  | sampling the stop bit: high -> valid, low -> frame_err
// UART_RX_BREAK | after a framing error, waiting for the line to go high
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int ETU_CYCLES = UART_ETU_CYCLES,
    parameter int HALF_ETU   = ETU_CYCLES / 2,
    parameter int CNT_W      = $clog2(ETU_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data_in,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_ETU - 1);
    localparam logic [CNT_W-1:0] ETU_LAST  = CNT_W'(ETU_CYCLES - 1);

    logic           rx_s;
    logic           sample_bit;
    uart_rx_state_t state;
    logic [CNT_W-1:0] etu_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift;

`ifdef UART_RX_MAJORITY_EN
    // The synchronizer is split in two. The first stage is the value that
    // rx_s will take on the next clock, so the vote can use the "one clock
    // after" sample while still resolving on the nominal clock.
    logic rx_early;
    logic rx_prev;

    uart_rx_sync #(.WIDTH(1), .STAGES(1)) u_sync_a (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rx_early)
    );

    uart_rx_sync #(.WIDTH(1), .STAGES(1)) u_sync_b (
        .clk (clk),
        .rst (rst),
        .d   (rx_early),
        .q   (rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_prev <= 1'b1;
        else      rx_prev <= rx_s;
    end

    assign sample_bit = maj3(rx_prev, rx_s, rx_early);
`else
    uart_rx_sync #(.WIDTH(1), .STAGES(2)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rx_s)
    );

    assign sample_bit = rx_s;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= UART_RX_IDLE;
            etu_cnt   <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            data_in   <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                UART_RX_IDLE: begin
                    busy    <= 1'b0;
                    etu_cnt <= '0;
                    bit_cnt <= '0;
                    // IDLE reacts to the raw synced level, so a start bit
                    // that directly follows a stop bit is not missed.
                    if (!rx_s) begin
                        state <= UART_RX_START;
                        busy  <= 1'b1;
                    end
                end

                UART_RX_START: begin
                    if (etu_cnt == HALF_LAST) begin
                        etu_cnt <= '0;
                        if (!sample_bit) begin
                            state   <= UART_RX_DATA;
                            bit_cnt <= '0;
                        end else begin
                            state <= UART_RX_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        etu_cnt <= etu_cnt + CNT_W'(1);
                    end
                end

                UART_RX_DATA: begin
                    if (etu_cnt == ETU_LAST) begin
                        etu_cnt <= '0;
                        shift   <= {sample_bit, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= UART_RX_STOP;
                    end else begin
                        etu_cnt <= etu_cnt + CNT_W'(1);
                    end
                end

                UART_RX_STOP: begin
                    if (etu_cnt == ETU_LAST) begin
                        etu_cnt <= '0;
                        if (sample_bit) begin
                            data_in <= shift;
                            valid   <= 1'b1;
                            state   <= UART_RX_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= UART_RX_BREAK;
                        end
                    end else begin
                        etu_cnt <= etu_cnt + CNT_W'(1);
                    end
                end

                UART_RX_BREAK: begin
                    // A line held low stays here, so a break produces only
                    // one frame_err.
                    if (rx_s) begin
                        state <= UART_RX_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= UART_RX_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
